// File: rtl/rv_timer_deadline_sched.sv
// Earliest-deadline scheduler that time-shares one rv_timer hart comparator among NReq requesters.
// Optional per-requester cancel path: define RV_TIMER_SCHED_CANCEL_EN.

module rv_timer_deadline_entry (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set,
  input  logic        clr,
  input  logic [63:0] set_time,
  output logic        valid,
  output logic [63:0] deadline
);
  // set wins over clr so an arm survives a same-cycle expiry or cancel of its slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      deadline <= '0;
    end else if (set) begin
      valid    <= 1'b1;
      deadline <= set_time;
    end else if (clr) begin
      valid    <= 1'b0;
    end
  end
endmodule

module rv_timer_deadline_sched #(
  parameter  int NReq = 4,
  localparam int IdW  = $clog2(NReq)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             arm_valid_i,
  output logic             arm_ready_o,
  input  logic [IdW-1:0]   arm_id_i,
  input  logic [63:0]      arm_time_i,
`ifdef RV_TIMER_SCHED_CANCEL_EN
  input  logic [NReq-1:0]  cancel_i,
`endif
  input  logic [63:0]      mtime_i,
  output logic [63:0]      cmp_o,
  output logic             cmp_we_o,
  output logic [NReq-1:0]  fire_o,
  output logic [NReq-1:0]  pending_o
);
  typedef enum logic [1:0] {IDLE, SCAN, ARMED} state_e;
  typedef struct packed {
    logic           found;
    logic [IdW-1:0] id;
    logic [63:0]    dl;
  } best_t;

  state_e                 state_q, state_d;
  best_t                  run_q, run_d;
  logic [IdW-1:0]         scan_idx, best_id;
  logic [63:0]            cmp_q, scan_cmp;
  logic                   cmp_we_q;
  logic [NReq-1:0]        fire_q, valid, set, clr, exp_hit, cancel_hit;
  logic [NReq-1:0][63:0]  deadline;
  logic                   ready, arm_ok, expire, scan_last;

  assign ready     = (state_q != SCAN);
  assign arm_ok    = arm_valid_i && ready && ({{(32-IdW){1'b0}}, arm_id_i} < NReq);
  assign expire    = (state_q == ARMED) && (mtime_i >= cmp_q);
  assign scan_last = (scan_idx == IdW'(NReq - 1));

`ifdef RV_TIMER_SCHED_CANCEL_EN
  assign cancel_hit = ready ? cancel_i : '0;
`else
  assign cancel_hit = '0;
`endif

  for (genvar k = 0; k < NReq; k++) begin : g_ent
    assign exp_hit[k] = expire && (best_id == IdW'(k));
    assign set[k]     = arm_ok && (arm_id_i == IdW'(k));
    assign clr[k]     = exp_hit[k] || cancel_hit[k];
    rv_timer_deadline_entry u_ent (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .set      (set[k]),
      .clr      (clr[k]),
      .set_time (arm_time_i),
      .valid    (valid[k]),
      .deadline (deadline[k])
    );
  end

  // strict less-than while walking upward keeps the lowest index on ties
  always_comb begin
    run_d = run_q;
    if (valid[scan_idx] && (!run_q.found || (deadline[scan_idx] < run_q.dl))) begin
      run_d.found = 1'b1;
      run_d.id    = scan_idx;
      run_d.dl    = deadline[scan_idx];
    end
  end

  assign scan_cmp = run_d.found ? run_d.dl : '1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ARMED: if (arm_ok || expire || (|cancel_hit)) state_d = SCAN;
      SCAN:        if (scan_last) state_d = run_d.found ? ARMED : IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      run_q    <= '0;
      scan_idx <= '0;
      best_id  <= '0;
      cmp_q    <= '1;
      cmp_we_q <= 1'b0;
      fire_q   <= '0;
    end else begin
      state_q  <= state_d;
      fire_q   <= exp_hit;
      cmp_we_q <= 1'b0;
      if (state_q != SCAN) begin
        scan_idx <= '0;
        run_q    <= '0;
      end else begin
        scan_idx <= scan_last ? '0 : scan_idx + IdW'(1);
        run_q    <= run_d;
        if (scan_last) begin
          cmp_q    <= scan_cmp;
          cmp_we_q <= (scan_cmp != cmp_q);
          if (run_d.found) best_id <= run_d.id;
        end
      end
    end
  end

  assign arm_ready_o = ready;
  assign cmp_o       = cmp_q;
  assign cmp_we_o    = cmp_we_q;
  assign fire_o      = fire_q;
  assign pending_o   = valid;
endmodule

// File: tb/tb_rv_timer_deadline_sched.sv
// Bench for rv_timer_deadline_sched: directed scenarios plus random arms against a table model.
// Cancel scenarios are built when RV_TIMER_SCHED_CANCEL_EN is defined.

module tb_rv_timer_deadline_sched;
  localparam int NReq = 4;
  localparam int IdW  = $clog2(NReq);
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic            clk = 1'b0, rst_ni = 1'b0, arm_valid = 1'b0;
  logic [IdW-1:0]  arm_id = '0;
  logic [63:0]     arm_time = '0, mtime = '0;
  logic [NReq-1:0] cancel = '0;
  logic            arm_ready, cmp_we;
  logic [63:0]     cmp;
  logic [NReq-1:0] fire, pending;
  int tests = 0, fails = 0;

  // reference: table contents, remaining scan cycles, last programmed compare
  bit [NReq-1:0]   m_valid;
  logic [63:0]     m_dl [NReq];
  int              m_busy, m_best;
  bit              m_armed, m_we, m_acc;
  logic [63:0]     m_cmp;
  logic [NReq-1:0] m_fire;

  rv_timer_deadline_sched #(.NReq(NReq)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .arm_valid_i(arm_valid), .arm_ready_o(arm_ready),
    .arm_id_i(arm_id), .arm_time_i(arm_time),
`ifdef RV_TIMER_SCHED_CANCEL_EN
    .cancel_i(cancel),
`endif
    .mtime_i(mtime), .cmp_o(cmp), .cmp_we_o(cmp_we), .fire_o(fire), .pending_o(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic model_reset();
    m_valid = '0; m_busy = 0; m_best = 0; m_armed = 0; m_we = 0; m_acc = 0;
    m_cmp = ALL1; m_fire = '0;
    for (int k = 0; k < NReq; k++) m_dl[k] = '0;
  endtask

  task automatic model_edge();
    bit ev, found;
    logic [63:0] mn;
    int mid;
    m_fire = '0; m_we = 0; m_acc = 0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        found = 0; mn = ALL1; mid = 0;
        for (int k = 0; k < NReq; k++)
          if (m_valid[k] && (!found || m_dl[k] < mn)) begin found = 1; mn = m_dl[k]; mid = k; end
        m_we = (mn != m_cmp);
        m_cmp = mn; m_armed = found;
        if (found) m_best = mid;
      end
    end else begin
      ev = 0;
      if (m_armed && mtime >= m_cmp) begin m_valid[m_best] = 0; m_fire[m_best] = 1'b1; ev = 1; end
`ifdef RV_TIMER_SCHED_CANCEL_EN
      for (int k = 0; k < NReq; k++) if (cancel[k]) begin m_valid[k] = 0; ev = 1; end
`endif
      if (arm_valid) begin
        m_acc = 1;
        if (int'(arm_id) < NReq) begin m_valid[arm_id] = 1; m_dl[arm_id] = arm_time; ev = 1; end
      end
      if (ev) m_busy = NReq;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run_idle();
    for (int i = 0; i < 2*NReq + 2; i++) begin
      if (m_busy == 0) break;
      step();
    end
  endtask

  task automatic arm(input int id, input logic [63:0] t);
    arm_valid = 1'b1; arm_id = IdW'(id); arm_time = t;
    for (int i = 0; i < 4*NReq; i++) begin
      step();
      if (m_acc) break;
    end
    arm_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (arm_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", arm_ready); end
    tests++; if (cmp !== ALL1) begin fails++; $display("FAIL rst_cmp: got %h want %h", cmp, ALL1); end
    tests++; if (pending !== '0 || fire !== '0 || cmp_we !== 1'b0) begin
      fails++; $display("FAIL rst_outs: pending=%b fire=%b we=%b want all 0", pending, fire, cmp_we); end
    @(negedge clk); rst_ni = 1'b1; model_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      tests++; if (cmp !== ALL1 || cmp_we !== 1'b0 || fire !== '0 || pending !== '0) begin
        fails++; $display("FAIL idle_%0d: cmp=%h we=%b fire=%b pending=%b want all-ones/0/0/0", i, cmp, cmp_we, fire, pending); end
    end
  endtask

  task automatic test_order();
    mtime = 0;
    arm(2, 100); arm(0, 50); run_idle();
    tests++; if (cmp !== 64'd50 || cmp_we !== 1'b1) begin fails++; $display("FAIL order_cmp50: cmp=%0d we=%b want 50/1", cmp, cmp_we); end
    tests++; if (pending !== 4'b0101) begin fails++; $display("FAIL order_pend: got %b want 0101", pending); end
    mtime = 50; step();
    tests++; if (fire !== 4'b0001) begin fails++; $display("FAIL order_fire0: got %b want 0001", fire); end
    tests++; if (pending !== 4'b0100) begin fails++; $display("FAIL order_pend2: got %b want 0100", pending); end
    run_idle();
    tests++; if (cmp !== 64'd100 || cmp_we !== 1'b1) begin fails++; $display("FAIL order_cmp100: cmp=%0d we=%b want 100/1", cmp, cmp_we); end
    mtime = 100; step();
    tests++; if (fire !== 4'b0100) begin fails++; $display("FAIL order_fire2: got %b want 0100", fire); end
    run_idle();
    tests++; if (cmp !== ALL1 || pending !== '0 || arm_ready !== 1'b1) begin
      fails++; $display("FAIL order_idle: cmp=%h pending=%b ready=%b want all-ones/0/1", cmp, pending, arm_ready); end
  endtask

  task automatic test_tie();
    mtime = 0;
    arm(1, 30); arm(3, 30); run_idle();
    tests++; if (cmp !== 64'd30) begin fails++; $display("FAIL tie_cmp: got %0d want 30", cmp); end
    mtime = 30; step();
    tests++; if (fire !== 4'b0010) begin fails++; $display("FAIL tie_fire1: got %b want 0010", fire); end
    run_idle();
    tests++; if (cmp !== 64'd30 || cmp_we !== 1'b0 || pending !== 4'b1000) begin
      fails++; $display("FAIL tie_rescan: cmp=%0d we=%b pending=%b want 30/0/1000", cmp, cmp_we, pending); end
    step();
    tests++; if (fire !== 4'b1000) begin fails++; $display("FAIL tie_fire3: got %b want 1000", fire); end
    run_idle();
    tests++; if (cmp !== ALL1) begin fails++; $display("FAIL tie_idle: got %h want %h", cmp, ALL1); end
  endtask

  task automatic test_past();
    mtime = 200;
    arm(0, 150); run_idle();
    tests++; if (cmp !== 64'd150 || fire !== '0) begin fails++; $display("FAIL past_armed: cmp=%0d fire=%b want 150/0", cmp, fire); end
    step();
    tests++; if (fire !== 4'b0001 || pending[0] !== 1'b0) begin
      fails++; $display("FAIL past_fire: fire=%b pending0=%b want 0001/0", fire, pending[0]); end
    run_idle();
  endtask

  task automatic test_arm_expire();
    mtime = 0;
    arm(0, 300); run_idle();
    tests++; if (arm_ready !== 1'b1) begin fails++; $display("FAIL ae_ready: got %b want 1", arm_ready); end
    mtime = 300; arm_valid = 1'b1; arm_id = '0; arm_time = 64'd500;
    step(); arm_valid = 1'b0;
    tests++; if (fire !== 4'b0001 || pending[0] !== 1'b1) begin
      fails++; $display("FAIL ae_fire: fire=%b pending0=%b want 0001/1", fire, pending[0]); end
    run_idle();
    tests++; if (cmp !== 64'd500 || pending !== 4'b0001) begin
      fails++; $display("FAIL ae_cmp: cmp=%0d pending=%b want 500/0001", cmp, pending); end
    mtime = 500; step();
    tests++; if (fire !== 4'b0001) begin fails++; $display("FAIL ae_fire2: got %b want 0001", fire); end
    run_idle();
  endtask

`ifdef RV_TIMER_SCHED_CANCEL_EN
  task automatic test_cancel();
    mtime = 0;
    arm(1, 40); arm(2, 60); run_idle();
    tests++; if (cmp !== 64'd40) begin fails++; $display("FAIL cxl_cmp40: got %0d want 40", cmp); end
    mtime = 10; cancel = 4'b0010; step(); cancel = '0;
    tests++; if (pending !== 4'b0100 || arm_ready !== 1'b0) begin
      fails++; $display("FAIL cxl_clear: pending=%b ready=%b want 0100/0", pending, arm_ready); end
    arm_valid = 1'b1; arm_id = 2'd3; arm_time = 64'd90;
    step();
    tests++; if (arm_ready !== 1'b0 || pending[3] !== 1'b0) begin
      fails++; $display("FAIL cxl_hold: ready=%b pending3=%b want 0/0", arm_ready, pending[3]); end
    arm(3, 90); run_idle();
    tests++; if (cmp !== 64'd60 || pending !== 4'b1100) begin
      fails++; $display("FAIL cxl_cmp60: cmp=%0d pending=%b want 60/1100", cmp, pending); end
    mtime = 100;
    for (int i = 0; i < 3*NReq + 4; i++) begin
      step();
      tests++; if (fire[1] !== 1'b0) begin fails++; $display("FAIL cxl_nofire1: cycle %0d fire=%b want bit1=0", i, fire); end
    end
    tests++; if (pending !== '0 || cmp !== ALL1) begin
      fails++; $display("FAIL cxl_end: pending=%b cmp=%h want 0/all-ones", pending, cmp); end
  endtask
`endif

  task automatic test_reset_mid();
    mtime = 0;
    arm(0, 20); step();
    rst_ni = 1'b0; #1;
    tests++; if (cmp !== ALL1 || arm_ready !== 1'b1 || pending !== '0) begin
      fails++; $display("FAIL rmid_scan: cmp=%h ready=%b pending=%b want all-ones/1/0", cmp, arm_ready, pending); end
    @(negedge clk); rst_ni = 1'b1; model_reset();
    mtime = 10;
    arm(1, 5); run_idle();
    rst_ni = 1'b0;
    @(posedge clk); #1;
    tests++; if (fire !== '0 || pending !== '0 || cmp !== ALL1) begin
      fails++; $display("FAIL rmid_armed: fire=%b pending=%b cmp=%h want 0/0/all-ones", fire, pending, cmp); end
    @(negedge clk); rst_ni = 1'b1; model_reset();
  endtask

  task automatic test_random();
    int r;
    mtime = 64'd1000;
    for (int c = 0; c < 3000; c++) begin
      if (!arm_valid && $urandom_range(0, 3) == 0) begin
        arm_valid = 1'b1;
        arm_id = IdW'($urandom_range(0, NReq - 1));
        r = $urandom_range(0, 7);
        if (r == 0)      arm_time = {1'b1, 31'($urandom), 32'($urandom)};
        else if (r == 1) arm_time = mtime - 64'($urandom_range(0, 20));
        else             arm_time = mtime + 64'($urandom_range(0, 60));
      end
`ifdef RV_TIMER_SCHED_CANCEL_EN
      cancel = ($urandom_range(0, 15) == 0) ? NReq'($urandom) : '0;
`endif
      step();
      tests++; if (arm_ready !== (m_busy == 0)) begin fails++; $display("FAIL rnd_ready c%0d: got %b want %b", c, arm_ready, (m_busy == 0)); end
      tests++; if (cmp !== m_cmp) begin fails++; $display("FAIL rnd_cmp c%0d: got %h want %h", c, cmp, m_cmp); end
      tests++; if (cmp_we !== m_we) begin fails++; $display("FAIL rnd_we c%0d: got %b want %b", c, cmp_we, m_we); end
      tests++; if (fire !== m_fire) begin fails++; $display("FAIL rnd_fire c%0d: got %b want %b", c, fire, m_fire); end
      tests++; if (pending !== m_valid) begin fails++; $display("FAIL rnd_pend c%0d: got %b want %b", c, pending, m_valid); end
      if (m_acc) arm_valid = 1'b0;
      mtime = mtime + 64'($urandom_range(0, 2));
    end
    arm_valid = 1'b0; cancel = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_order();
    test_tie();
    test_past();
    test_arm_expire();
`ifdef RV_TIMER_SCHED_CANCEL_EN
    test_cancel();
`endif
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
